add_identity_rows: RTL and testbench
====================================

Name: add_identity_rows

Overview:
- Streaming block that adds the identity matrix to an M×M fixed-point matrix, one row per transfer. Row r has 1.0 added to element r.
- Inverse of the pseudoinverse datapath's subtract-identity stage. Restores (A − I) back to A and builds (AᵀA + I) terms.
- Ready/valid on both sides with a 2-entry skid buffer, so the block sustains one row per clock with a registered in_ready.

Parameters:
- M, 4, matrix dimension: elements per row and rows per matrix.
- nBits, 32, element width in two's-complement fixed point.
- FRAC, 15, fractional bits. 1.0 = 1 << FRAC.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- clr  input  1  synchronous restart: next accepted row is row 0
- in_valid  input  1  in_row holds a valid row
- in_ready  output  1  block can accept a row; driven from a register
- in_row  input  [0:nBits*M-1]  row; element k = in_row[k*nBits +: nBits]
- out_valid  output  1  out_row holds a valid row
- out_ready  input  1  downstream accepts out_row
- out_row  output  [0:nBits*M-1]  processed row, same packing as in_row
- out_idx  output  [$clog2(M)-1:0]  row index of out_row
- out_last  output  1  out_row is row M-1
- ovf  output  1  sticky flag: a diagonal add overflowed

Behaviour:
- Reset (rst_n=0 at posedge):
  - in_ready=1, out_valid=0, out_row=0, out_idx=0, out_last=0, ovf=0.
  - Row counter = 0; skid buffer empty.
  - Reset mid-matrix discards any buffered rows; no partial output survives.
- Accept and emit:
  - A row is accepted on a posedge with in_valid && in_ready.
  - Output transfers on a posedge with out_valid && out_ready.
- Row counter:
  - Increments on each accepted row and wraps M-1 → 0.
  - The accepted row is tagged with the counter value at acceptance.
- Arithmetic:
  - Diagonal element idx becomes elem + (1<<FRAC), computed at nBits width with two's-complement wrap.
  - Every other element passes through unchanged.
- Overflow: ovf sets when the two operands of the diagonal add are both non-negative and the sum's MSB is 1. It stays set until reset or clr.
- Latency: 1 cycle. A row accepted at edge t is presented with out_valid=1 after edge t when the buffer was empty.
- Skid buffer (2 entries, main output register plus skid register):
  - Empty → one: on accept, no emit.
  - One → two: on accept with out_ready=0. in_ready drops to 0 on that same edge.
  - One → one: accept and emit on the same edge.
  - Two → one: on emit. in_ready returns to 1.
  - Rows leave in acceptance order. No row is duplicated or dropped.
  - out_row, out_idx and out_last hold stable while out_valid && !out_ready.
- clr (synchronous):
  - Counter → 0 and ovf → 0.
  - Buffered rows keep the tags they already have.
  - clr and accept on the same edge: the accepted row is tagged row 0 and the counter becomes 1.
  - clr and rst_n=0 together: reset wins.
- out_last = (out_idx == M-1).

Optional Feature:
- Macro ADD_IDENTITY_SATURATE_EN.
- Defined: a diagonal add that would overflow is clamped to the largest positive value, 2^(nBits-1)-1. ovf still sets.
- Undefined: the result wraps modulo 2^nBits. ovf behaviour is identical in both builds.

Test Plan:
1. Reset, then 4 zero rows with out_ready=1:
   - Outputs: row r has element r = 0x00008000, other elements 0.
   - out_idx 0,1,2,3; out_last only on row 3; one row per cycle, 1-cycle latency.
2. Backpressure:
   - Hold out_ready=0 while sending rows 0 and 1. in_ready goes 0 after the second accept.
   - Release out_ready: both rows emerge in order with correct diagonals. No loss and no duplication.
3. Wrap: send 6 rows of 0x00010000.
   - out_idx sequence 0,1,2,3,0,1.
   - Diagonal elements = 0x00018000.
4. clr mid-matrix: after 2 rows, assert clr together with row data 0x00000000.
   - That row exits with out_idx=0 and element 0 = 0x00008000.
5. Overflow, row 0 element 0 = 0x7FFFC000:
   - Macro undefined: output 0x80004000, ovf=1.
   - Macro defined: output 0x7FFFFFFF, ovf=1.
   - ovf clears on clr.
6. Reset mid-stream:
   - With 2 rows buffered and out_ready=0, pull rst_n=0 for one edge.
   - out_valid=0, in_ready=1, next accepted row tagged out_idx=0.

Source files
------------

// File: rtl/add_identity_rows.sv
// Adds identity to an MxM fixed-point matrix streamed one row per transfer; 1-cycle latency, 2-entry skid buffer.
// Backpressure: registered in_ready drops when both entries are full. Optional ADD_IDENTITY_SATURATE_EN clamps overflowing diagonals.
module add_identity_rows #(
  parameter int M     = 4,
  parameter int nBits = 32,
  parameter int FRAC  = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:nBits*M-1]     in_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:nBits*M-1]     out_row,
  output logic [$clog2(M)-1:0]   out_idx,
  output logic                   out_last,
  output logic                   ovf
);

  localparam int IW = $clog2(M);
  localparam int RW = nBits * M;
  localparam logic [nBits-1:0] ONE  = nBits'(1) << FRAC;
  localparam logic [IW-1:0]    LAST = IW'(M - 1);

  logic [IW-1:0]    cnt, tag, main_idx, skid_idx;
  logic [0:RW-1]    proc_row, main_row, skid_row;
  logic             main_vld, skid_vld, rdy_q, ovf_q, proc_ovf;
  logic [nBits-1:0] elem, sum;
  logic             acc;

  assign acc = in_valid && rdy_q;
  // clr retags the row arriving on the same edge as row 0
  assign tag = clr ? '0 : cnt;

  always_comb begin
    proc_row = in_row;
    proc_ovf = 1'b0;
    elem     = '0;
    sum      = '0;
    for (int k = 0; k < M; k++) begin
      if (k == int'(tag)) begin
        elem = in_row[k*nBits +: nBits];
        sum  = elem + ONE;
        if (!elem[nBits-1] && sum[nBits-1]) begin
          proc_ovf = 1'b1;
`ifdef ADD_IDENTITY_SATURATE_EN
          sum = {1'b0, {(nBits-1){1'b1}}};
`else
          sum = elem + ONE;
`endif
        end
        proc_row[k*nBits +: nBits] = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      ovf_q    <= 1'b0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
      main_row <= '0;
      main_idx <= '0;
      skid_row <= '0;
      skid_idx <= '0;
    end else begin
      if (acc)
        cnt <= (tag == LAST) ? '0 : tag + IW'(1);
      else if (clr)
        cnt <= '0;
      ovf_q <= (ovf_q && !clr) || (acc && proc_ovf);

      // in_ready is low whenever the skid entry is occupied, so no accept here
      if (skid_vld) begin
        if (out_ready) begin
          main_row <= skid_row;
          main_idx <= skid_idx;
          skid_vld <= 1'b0;
          rdy_q    <= 1'b1;
        end
      end else if (main_vld) begin
        if (acc && !out_ready) begin
          skid_row <= proc_row;
          skid_idx <= tag;
          skid_vld <= 1'b1;
          rdy_q    <= 1'b0;
        end else if (acc) begin
          main_row <= proc_row;
          main_idx <= tag;
        end else if (out_ready) begin
          main_vld <= 1'b0;
        end
      end else if (acc) begin
        main_row <= proc_row;
        main_idx <= tag;
        main_vld <= 1'b1;
      end
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = main_vld;
  assign out_row   = main_row;
  assign out_idx   = main_idx;
  assign out_last  = (main_idx == LAST);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_identity_rows.sv
// Directed table-driven bench for add_identity_rows, plus backpressure and mid-stream reset sequences.
module tb_add_identity_rows;

  logic         clk = 1'b0;
  logic         rst_n, clr, in_valid, out_ready;
  logic         in_ready, out_valid, out_last, ovf;
  logic [0:127] in_row, out_row;
  logic [1:0]   out_idx;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  add_identity_rows #(.M(4), .nBits(32), .FRAC(15)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_idx(out_idx), .out_last(out_last), .ovf(ovf)
  );

`ifdef ADD_IDENTITY_SATURATE_EN
  localparam logic [31:0] OV14 = 32'h7FFFFFFF;
  localparam logic [31:0] OV17 = 32'h7FFFFFFF;
`else
  localparam logic [31:0] OV14 = 32'h80004000;
  localparam logic [31:0] OV17 = 32'h80000000;
`endif

  typedef struct {
    logic [127:0] row;
    logic         clr;
    logic [127:0] exp_row;
    logic [1:0]   exp_idx;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // element 0 is the leftmost word
    vecs[0]  = '{128'h0, 0, {32'h8000, 32'h0, 32'h0, 32'h0}, 2'd0, 0};
    vecs[1]  = '{128'h0, 0, {32'h0, 32'h8000, 32'h0, 32'h0}, 2'd1, 0};
    vecs[2]  = '{128'h0, 0, {32'h0, 32'h0, 32'h8000, 32'h0}, 2'd2, 0};
    vecs[3]  = '{128'h0, 0, {32'h0, 32'h0, 32'h0, 32'h8000}, 2'd3, 0};
    vecs[4]  = '{{4{32'h10000}}, 0, {32'h18000, 32'h10000, 32'h10000, 32'h10000}, 2'd0, 0};
    vecs[5]  = '{{4{32'h10000}}, 0, {32'h10000, 32'h18000, 32'h10000, 32'h10000}, 2'd1, 0};
    vecs[6]  = '{{4{32'h10000}}, 0, {32'h10000, 32'h10000, 32'h18000, 32'h10000}, 2'd2, 0};
    vecs[7]  = '{{4{32'h10000}}, 0, {32'h10000, 32'h10000, 32'h10000, 32'h18000}, 2'd3, 0};
    vecs[8]  = '{{4{32'h10000}}, 0, {32'h18000, 32'h10000, 32'h10000, 32'h10000}, 2'd0, 0};
    vecs[9]  = '{{4{32'h10000}}, 0, {32'h10000, 32'h18000, 32'h10000, 32'h10000}, 2'd1, 0};
    vecs[10] = '{128'h0, 1, {32'h8000, 32'h0, 32'h0, 32'h0}, 2'd0, 0};
    vecs[11] = '{128'h0, 0, {32'h0, 32'h8000, 32'h0, 32'h0}, 2'd1, 0};
    vecs[12] = '{{32'h12345678, 32'h0, 32'hFFFF8000, 32'h1}, 0,
                 {32'h12345678, 32'h0, 32'h0, 32'h1}, 2'd2, 0};
    vecs[13] = '{{32'h0, 32'h0, 32'h0, 32'h80000000}, 0,
                 {32'h0, 32'h0, 32'h0, 32'h80008000}, 2'd3, 0};
    vecs[14] = '{{32'h7FFFC000, 32'hAAAA, 32'h0, 32'h0}, 0,
                 {OV14, 32'hAAAA, 32'h0, 32'h0}, 2'd0, 1};
    vecs[15] = '{128'h0, 1, {32'h8000, 32'h0, 32'h0, 32'h0}, 2'd0, 0};
    vecs[16] = '{{32'h0, 32'h7FFF7FFF, 32'h0, 32'h0}, 0,
                 {32'h0, 32'h7FFFFFFF, 32'h0, 32'h0}, 2'd1, 0};
    vecs[17] = '{{32'h0, 32'h0, 32'h7FFF8000, 32'h0}, 0,
                 {32'h0, 32'h0, OV17, 32'h0}, 2'd2, 1};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_row = '0;
    @(posedge clk); tick();
    chk("rst in_ready", 128'(in_ready), 128'd1);
    chk("rst out_valid", 128'(out_valid), 128'd0);
    chk("rst out_row", out_row, 128'h0);
    chk("rst out_idx", 128'(out_idx), 128'd0);
    chk("rst out_last", 128'(out_last), 128'd0);
    chk("rst ovf", 128'(ovf), 128'd0);
    rst_n = 1'b1;

    // Streaming at one row per clock with out_ready held high
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1;
      in_row   = vecs[i].row;
      clr      = vecs[i].clr;
      tick();
      chk($sformatf("v%0d valid", i), 128'(out_valid), 128'd1);
      chk($sformatf("v%0d row", i), out_row, vecs[i].exp_row);
      chk($sformatf("v%0d idx", i), 128'(out_idx), 128'(vecs[i].exp_idx));
      chk($sformatf("v%0d last", i), 128'(out_last), 128'(vecs[i].exp_idx == 2'd3));
      chk($sformatf("v%0d ovf", i), 128'(ovf), 128'(vecs[i].exp_ovf));
    end
    in_valid = 1'b0; clr = 1'b0;
    tick();
    chk("drain valid", 128'(out_valid), 128'd0);

    // Backpressure: fill both entries, then drain
    out_ready = 1'b0; in_valid = 1'b1; clr = 1'b1; in_row = {4{32'h10000}};
    tick();
    chk("bp1 valid", 128'(out_valid), 128'd1);
    chk("bp1 in_ready", 128'(in_ready), 128'd1);
    chk("bp1 idx", 128'(out_idx), 128'd0);
    clr = 1'b0; in_row = {4{32'h20000}};
    tick();
    chk("bp2 in_ready", 128'(in_ready), 128'd0);
    chk("bp2 row", out_row, {32'h18000, 32'h10000, 32'h10000, 32'h10000});
    in_row = {4{32'h30000}};
    tick();
    chk("bp3 hold row", out_row, {32'h18000, 32'h10000, 32'h10000, 32'h10000});
    chk("bp3 hold idx", 128'(out_idx), 128'd0);
    chk("bp3 in_ready", 128'(in_ready), 128'd0);
    out_ready = 1'b1;
    tick();
    chk("bp4 row", out_row, {32'h20000, 32'h28000, 32'h20000, 32'h20000});
    chk("bp4 idx", 128'(out_idx), 128'd1);
    chk("bp4 in_ready", 128'(in_ready), 128'd1);
    tick();
    chk("bp5 row", out_row, {32'h30000, 32'h30000, 32'h38000, 32'h30000});
    chk("bp5 idx", 128'(out_idx), 128'd2);
    in_valid = 1'b0;
    tick();
    chk("bp6 valid", 128'(out_valid), 128'd0);

    // Reset with two rows buffered
    out_ready = 1'b0; in_valid = 1'b1; in_row = {4{32'h50000}};
    tick();
    tick();
    chk("rs full in_ready", 128'(in_ready), 128'd0);
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rs out_valid", 128'(out_valid), 128'd0);
    chk("rs in_ready", 128'(in_ready), 128'd1);
    chk("rs ovf", 128'(ovf), 128'd0);
    out_ready = 1'b1; in_valid = 1'b1; in_row = '0;
    tick();
    chk("rs next idx", 128'(out_idx), 128'd0);
    chk("rs next row", out_row, {32'h8000, 32'h0, 32'h0, 32'h0});
    in_valid = 1'b0;
    tick();
    chk("rs no stale", 128'(out_valid), 128'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
